// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared hold-bus encodings, FSM state codes and common constants for the pipeline hold controller.
package pipe_hold_ctrl_pkg;

  localparam logic [2:0]  HOLD_NONE = 3'd0;
  localparam logic [2:0]  HOLD_PC   = 3'd1;
  localparam logic [2:0]  HOLD_IF   = 3'd2;
  localparam logic [2:0]  HOLD_ID   = 3'd3;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold arbiter: merges stall sources into one hold level, sequences jump flushes and
// debug halt, and keeps a saturating count of held cycles.
//
// state | meaning
// IDLE  | no flush or halt in progress
// FLUSH | ID/EX held with NOP injection for FLUSH_CYCLES after a jump
// HALT  | core halted by debugger, PC held
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_ex_i,
  input  logic             hold_flag_rib_i,
  input  logic             hold_flag_clint_i,
  input  logic             jtag_halt_flag_i,
  input  logic             cnt_clr_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 4'd0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_q     <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (jump_flag_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end else if (jtag_halt_flag_i) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        // a halt raised mid-flush is simply sampled here on the way out
        if (jump_flag_i) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q == 4'd0) begin
          state_d = jtag_halt_flag_i ? ST_HALT : ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_HALT: begin
        if (jump_flag_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end else if (!jtag_halt_flag_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    hold_flag_o = HOLD_NONE;
    if (jump_flag_i || (state_q == ST_FLUSH) || hold_flag_ex_i || hold_flag_clint_i) begin
      hold_flag_o = HOLD_ID;
    end else if (hold_flag_rib_i || (state_q == ST_HALT)) begin
      hold_flag_o = HOLD_PC;
    end
    jump_flag_o = jump_flag_i;
    jump_addr_o = jump_flag_i ? jump_addr_i : ZERO_WORD;
    halted_o    = (state_q == ST_HALT);
  end

  always_comb begin
    stall_d = stall_q;
    if (cnt_clr_i) begin
      stall_d = '0;
    end else if ((hold_flag_o != HOLD_NONE) && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: a remaining-cycles model checked every cycle plus directed literal checks.
module tb_pipe_hold_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        hold_flag_clint_i = 1'b0;
  logic        jtag_halt_flag_i = 1'b0;
  logic        cnt_clr_i = 1'b0;

  logic [2:0]  hold_flag_o, hold_flag4;
  logic        jump_flag_o, jump_flag4;
  logic [31:0] jump_addr_o, jump_addr4;
  logic        halted_o, halted4;
  logic [31:0] stall_cycles_o;
  logic [3:0]  stall4;

  int checks_total = 0;
  int checks_pass  = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .hold_flag_clint_i(hold_flag_clint_i), .jtag_halt_flag_i(jtag_halt_flag_i),
    .cnt_clr_i(cnt_clr_i),
    .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .halted_o(halted_o), .stall_cycles_o(stall_cycles_o)
  );

  pipe_hold_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .hold_flag_clint_i(hold_flag_clint_i), .jtag_halt_flag_i(jtag_halt_flag_i),
    .cnt_clr_i(cnt_clr_i),
    .hold_flag_o(hold_flag4), .jump_flag_o(jump_flag4), .jump_addr_o(jump_addr4),
    .halted_o(halted4), .stall_cycles_o(stall4)
  );

  // Model: number of upcoming cycles still forced to Hold_Id by a flush, plus a halted bit.
  int          m_flush_left = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_stall32 = 32'h0;
  int          m_stall4 = 0;

  function automatic logic [2:0] exp_hold();
    if (jump_flag_i || m_flush_left > 0 || hold_flag_ex_i || hold_flag_clint_i) return 3'd3;
    if (hold_flag_rib_i || m_halted) return 3'd1;
    return 3'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flush_left = 0;
      m_halted     = 1'b0;
      m_stall32    = 32'h0;
      m_stall4     = 0;
    end else begin
      if (cnt_clr_i) begin
        m_stall32 = 32'h0;
        m_stall4  = 0;
      end else if (exp_hold() != 3'd0) begin
        if (m_stall32 != 32'hFFFF_FFFF) m_stall32 = m_stall32 + 32'd1;
        if (m_stall4 < 15) m_stall4 = m_stall4 + 1;
      end
      if (jump_flag_i) begin
        m_flush_left = FC;
        m_halted     = 1'b0;
      end else if (m_flush_left > 1) begin
        m_flush_left = m_flush_left - 1;
      end else begin
        m_flush_left = 0;
        m_halted     = jtag_halt_flag_i;
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks_total++;
    if (got == exp) checks_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("model_hold",     hold_flag_o, exp_hold());
      chk("model_hold4",    hold_flag4, exp_hold());
      chk("model_jflag",    jump_flag_o, jump_flag_i);
      chk("model_jaddr",    jump_addr_o, jump_flag_i ? jump_addr_i : 32'h0);
      chk("model_halted",   halted_o, m_halted);
      chk("model_halted4",  halted4, m_halted);
      chk("model_stall32",  stall_cycles_o, m_stall32);
      chk("model_stall4",   stall4, m_stall4);
    end
  end

  task automatic drive(input bit j, input logic [31:0] a, input bit ex, input bit rib,
                       input bit clint, input bit jtag, input bit clr);
    jump_flag_i       = j;
    jump_addr_i       = a;
    hold_flag_ex_i    = ex;
    hold_flag_rib_i   = rib;
    hold_flag_clint_i = clint;
    jtag_halt_flag_i  = jtag;
    cnt_clr_i         = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_hold", hold_flag_o, 0);
    chk("rst_stall", stall_cycles_o, 0);
    chk("rst_halted", halted_o, 0);

    // single jump pulse: Hold_Id for the jump cycle plus FC flush cycles
    drive(1, 32'h100, 0, 0, 0, 0, 0);
    chk("j_addr", jump_addr_o, 32'h100);
    chk("j_hold0", hold_flag_o, 3);
    tick();
    drive(0, 32'h55, 0, 0, 0, 0, 0);
    chk("j_addr_gated", jump_addr_o, 0);
    chk("j_hold1", hold_flag_o, 3);
    tick();
    chk("j_hold2", hold_flag_o, 3);
    tick();
    chk("j_hold3", hold_flag_o, 0);
    chk("j_stall", stall_cycles_o, 3);

    // back-to-back jump restarts the flush
    drive(1, 32'h200, 0, 0, 0, 0, 0);
    tick();
    drive(1, 32'h204, 0, 0, 0, 0, 0);
    chk("jj_hold1", hold_flag_o, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("jj_hold2", hold_flag_o, 3);
    tick();
    chk("jj_hold3", hold_flag_o, 3);
    tick();
    chk("jj_hold4", hold_flag_o, 0);
    chk("jj_stall", stall_cycles_o, 7);

    // rib + ex priority
    drive(0, 0, 1, 1, 0, 0, 0);
    chk("rx_hold", hold_flag_o, 3);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rib_hold", hold_flag_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("none_hold", hold_flag_o, 0);
    chk("rx_stall", stall_cycles_o, 9);

    // ex and clint holds leave the FSM alone
    drive(0, 0, 1, 0, 1, 0, 0);
    chk("exc_hold", hold_flag_o, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("exc_after", hold_flag_o, 0);
    chk("exc_halted", halted_o, 0);

    // halt raised during flush is taken on flush exit
    drive(1, 32'h300, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("fh_hold1", hold_flag_o, 3);
    chk("fh_nothalt", halted_o, 0);
    tick();
    chk("fh_hold2", hold_flag_o, 3);
    tick();
    chk("fh_halted", halted_o, 1);
    chk("fh_hold_pc", hold_flag_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fh_still", halted_o, 1);
    tick();
    chk("fh_idle", halted_o, 0);
    chk("fh_idle_hold", hold_flag_o, 0);

    // jump out of halt goes to flush
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("hj_halted", halted_o, 1);
    drive(1, 32'h400, 0, 0, 0, 1, 0);
    chk("hj_hold", hold_flag_o, 3);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("hj_flush", halted_o, 0);
    chk("hj_flush_hold", hold_flag_o, 3);
    tick();
    tick();
    chk("hj_rehalt", halted_o, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // clear, then saturate the 4-bit counter
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("clr_stall", stall_cycles_o, 0);
    repeat (20) tick();
    chk("sat_stall4", stall4, 15);
    chk("sat_stall32", stall_cycles_o, 20);
    drive(0, 0, 1, 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("sat_clr4", stall4, 0);
    tick();
    chk("sat_inc4", stall4, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    // async reset mid-flush aborts it
    drive(1, 32'h500, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rf_flush", hold_flag_o, 3);
    #1 rst = 1'b1;
    #1;
    chk("rf_hold", hold_flag_o, 0);
    chk("rf_stall", stall_cycles_o, 0);
    chk("rf_halted", halted_o, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rf_rel_hold", hold_flag_o, 0);
    tick();
    chk("rf_rel_hold2", hold_flag_o, 0);
    chk("rf_rel_stall", stall_cycles_o, 0);

    done = 1'b1;
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
